// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry.
// It adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
//
// Handshake (valid/ready): start is the request. It is accepted on any rising
// edge where the block is not busy (state IDLE or DONE). Operands are captured
// on that same edge. A start seen while busy is ignored and has no side effect.
// done pulses for exactly one cycle when sum/cout take the new result.
// A start during that DONE cycle begins the next run with no idle gap.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The bit counter must reach WIDTH-1. The width is at least 1 so that
  // WIDTH=1 still has a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sa;       // operand A shift register, LSB consumed first
  logic [WIDTH-1:0] sb;       // operand B shift register
  logic [WIDTH-1:0] ps;       // partial sum, filled from the MSB side
  logic [WIDTH-1:0] ps_nxt;   // partial sum after this cycle's bit
  logic [WIDTH-1:0] s_msb;    // this cycle's sum bit placed at the MSB
  logic             cr;       // carry between bit positions
  logic [CW-1:0]    cnt;      // index of the bit being processed

  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  // Full-adder cell on the current LSBs and the carry, plus the shifted partial sum.
  always_comb begin
    fa_s           = sa[0] ^ sb[0] ^ cr;
    fa_c           = (sa[0] & sb[0]) | (cr & (sa[0] ^ sb[0]));
    s_msb          = '0;
    s_msb[WIDTH-1] = fa_s;
    // Shifting right and then OR-ing in the MSB also works when WIDTH=1.
    ps_nxt         = (ps >> 1) | s_msb;
  end

  // A request is taken only when not running. The run ends on the last bit.
  assign accept = (state != RUN) && start;
  assign last   = (state == RUN) && (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. busy and done are decoded directly from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = accept ? RUN : IDLE;
      end
      RUN: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : RUN;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, process one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      ps   <= '0;
      cr   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      ps  <= '0;
      cr  <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      ps  <= ps_nxt;
      cr  <= fa_c;
      cnt <= cnt + CW'(1);
      // sum/cout change only here, so no intermediate bits are ever visible.
      if (last) begin
        sum  <= ps_nxt;
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder. It uses a WIDTH=8 instance for the main
// behaviour and a WIDTH=1 instance for the registered full-adder case.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // ---------------- scoreboard ----------------
  int total  = 0;
  int passed = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference model: plain integer addition of the operands and the carry-in.
  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned r;
    r = int'(x) + int'(y) + int'(c);
    return 9'(r % 512);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=8 run from the current cycle (the DUT must be in IDLE or DONE)
  // and follow it to the done cycle. If inject is in 0..7, a start carrying
  // different operands is asserted during RUN cycle number inject; it must be ignored.
  // The task returns positioned in the done cycle, with start low.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input int inject, input string name);
    logic [8:0] exp;
    logic [7:0] hold_s;
    logic       hold_c;
    int         bad_busy;
    int         bad_hold;
    exp    = ref_add8(ta, tb_v, tc);
    hold_s = sum8;
    hold_c = cout8;
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    tick();
    // Operands changed after the capture edge must not matter.
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    bad_busy = 0;
    bad_hold = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad_busy++;
      if (sum8 !== hold_s || cout8 !== hold_c) bad_hold++;
      if (i == inject) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    start8 = 1'b0;
    check({name, " busy8 cycles"}, 64'(bad_busy), 64'd0);
    check({name, " held during run"}, 64'(bad_hold), 64'd0);
    check({name, " done/busy"}, {62'd0, done8, busy8}, 64'b10);
    check({name, " cout,sum"}, {55'd0, cout8, sum8}, {55'd0, exp});
  endtask

  // One cycle later with no new start: done must have dropped and the result must hold.
  task automatic idle_after8(input string name, input logic [8:0] exp);
    tick();
    check({name, " done pulse 1 cycle"}, {62'd0, done8, busy8}, 64'b00);
    check({name, " result held"}, {55'd0, cout8, sum8}, {55'd0, exp});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t fa_tab[8];
  vec_t w8_tab[4];

  initial begin
    int acc;
    int dn;
    int k;
    logic [8:0] got9;

    // Full-adder truth table (WIDTH=1 uses bit 0 of a, b and sum).
    fa_tab[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    fa_tab[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0};
    fa_tab[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0};
    fa_tab[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    fa_tab[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    fa_tab[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1};
    fa_tab[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1};
    fa_tab[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};

    // Hand-computed WIDTH=8 vectors.
    w8_tab[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    w8_tab[1] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    w8_tab[2] = '{8'hFE, 8'h01, 1'b1, 8'h00, 1'b1};
    w8_tab[3] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset dut8 outputs", {53'd0, busy8, done8, cout8, sum8}, 64'd0);
    check("reset dut1 outputs", {60'd0, busy1, done1, cout1, sum1}, 64'd0);
    rst = 1'b0;
    tick();

    // WIDTH=1: each combination is started from IDLE and is done one cycle after the start edge.
    for (int i = 0; i < 8; i++) begin
      a1 = fa_tab[i].a[0:0]; b1 = fa_tab[i].b[0:0]; cin1 = fa_tab[i].cin; start1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      check($sformatf("w1[%0d] busy", i), {62'd0, busy1, done1}, 64'b10);
      tick();
      check($sformatf("w1[%0d] done,cout,sum", i), {61'd0, done1, cout1, sum1},
            {61'd0, 1'b1, fa_tab[i].cout, fa_tab[i].sum[0]});
      tick();
      check($sformatf("w1[%0d] idle", i), {62'd0, busy1, done1}, 64'b00);
    end

    // WIDTH=8 table vectors, each followed by an idle cycle.
    for (int i = 0; i < 4; i++) begin
      run8(w8_tab[i].a, w8_tab[i].b, w8_tab[i].cin, -1, $sformatf("w8[%0d]", i));
      check($sformatf("w8[%0d] table", i), {55'd0, cout8, sum8}, {55'd0, w8_tab[i].cout, w8_tab[i].sum});
      idle_after8($sformatf("w8[%0d]", i), {w8_tab[i].cout, w8_tab[i].sum});
    end

    // Back-to-back: the second start is issued in the DONE cycle of the first.
    run8(8'hFF, 8'h01, 1'b0, -1, "b2b first");
    run8(8'hA5, 8'h5A, 1'b1, -1, "b2b second");
    idle_after8("b2b", 9'h100);

    // A start asserted mid-run with other operands is ignored.
    run8(8'h10, 8'h20, 1'b0, 4, "ignored start");
    idle_after8("ignored start", 9'h030);

    // Asynchronous reset in the middle of bit 5 of a run.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset outputs", {53'd0, busy8, done8, cout8, sum8}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 !== 1'b0 || busy8 !== 1'b0) k++;
      tick();
    end
    check("no done after reset", 64'(k), 64'd0);
    run8(8'h80, 8'h80, 1'b0, -1, "after reset");
    idle_after8("after reset", 9'h100);

    // Random runs checked against the reference model through the expected queue.
    acc = 0;
    dn  = 0;
    for (int n = 0; n < 200; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
      exp_q.push_back(ref_add8(a8, b8, cin8));
      acc++;
      tick();
      start8 = 1'b0;
      k = 0;
      while (done8 !== 1'b1 && k < 40) begin
        // Noise on the inputs while busy, including ignored start requests.
        start8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        tick();
        k++;
      end
      start8 = 1'b0;
      if (done8 !== 1'b1) begin
        check($sformatf("random run %0d done timeout", n), 64'(done8), 64'd1);
        void'(exp_q.pop_front());
      end else begin
        dn++;
        got9 = {cout8, sum8};
        check($sformatf("random run %0d", n), {55'd0, got9}, {55'd0, exp_q.pop_front()});
        check($sformatf("random run %0d latency", n), 64'(k), 64'd8);
      end
      // Either chain straight from the DONE cycle or pass through IDLE first.
      if ($urandom_range(0, 1) == 1) tick();
    end
    check("done count vs accepted", 64'(dn), 64'(acc));
    check("expected queue drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder built around a single full-adder cell and a registered carry.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Sits downstream of the combinational full adder. It reuses that cell's sum/carry equations and turns them into a multi-bit, area-minimal adder with a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only when not busy
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while addition in progress
- done  output  1  one-cycle pulse when result becomes valid
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry-out

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset, asynchronous on rst rising:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry register and bit counter cleared
- Any operation in flight when rst asserts is abandoned. No done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E0 (operand capture):
  - a and b loaded into shift registers sa/sb; carry register cr<=cin; counter<=0
  - next state RUN
- IDLE or DONE, start=0: next state IDLE.
- RUN, each edge (one bit per edge):
  - s = sa[0]^sb[0]^cr
  - c = (sa[0]&sb[0]) | (cr&(sa[0]^sb[0]))
  - s shifted into the MSB of the partial-sum register ps; ps shifts right
  - sa, sb shift right; cr<=c; counter increments
- RUN, on the edge processing bit WIDTH-1 (counter==WIDTH-1):
  - sum<={s, ps[WIDTH-1:1]} (full result), cout<=c
  - state<=DONE
- Latency:
  - start accepted at E0; result registered at edge E(WIDTH)
  - done=1 for exactly the cycle after E(WIDTH)
  - WIDTH=8: done high after the 8th edge following the start edge
- busy=1 exactly while state==RUN (WIDTH cycles). done=1 exactly while state==DONE.
- start while busy: ignored. Operands, progress and result are unaffected.
- Back-to-back: start=1 during the DONE cycle is accepted, so a new run begins with no idle cycle.
- sum/cout hold the last completed result until the next completion. They do not change during RUN, so intermediate bits are never visible.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts one cycle. The block reduces to a registered full adder.
- a/b/cin may change freely after the capture edge without effect.

Test Plan:
- WIDTH=1, all 8 combinations of a,b,cin, each started from IDLE -> sum/cout match the full-adder truth table; e.g. 1,1,1 -> sum=1, cout=1; 1,0,1 -> sum=0, cout=1; done 1 cycle after start edge.
- WIDTH=8, a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0. busy high 8 cycles, then done pulse of exactly 1 cycle.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 issued during the DONE cycle -> sum=0x00, cout=1, with no idle gap.
- WIDTH=8, a=0x10, b=0x20, start; during cycle 4 assert start with a=0xFF, b=0xFF -> second start ignored; result sum=0x30, cout=0; inputs changed mid-run have no effect.
- WIDTH=8, start a=0x80, b=0x80; assert rst asynchronously mid-cycle at RUN bit 5 -> outputs immediately 0, busy=0, no done pulse. After release a new start with a=0x80, b=0x80 -> sum=0x00, cout=1.
- WIDTH=8, 200 random a/b/cin runs, checked against the a+b+cin reference model -> all {cout,sum} match; done count equals start-accepted count.
